// File: rtl/mmio_bus_ctrl.sv
// Memory-mapped bus controller: routes CPU data accesses to NSLV windowed slaves
// through a registered request/ready handshake with a response watchdog.
module mmio_bus_ctrl #(
  parameter int unsigned NSLV = 3,
  parameter int unsigned AW   = 64,
  parameter int unsigned DW   = 64,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {64'hA000_0048, 64'hA000_03F8, 64'h8000_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {~64'h7, ~64'h7, ~64'h7FF_FFFF},
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ECW  = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               acs_en,
  input  logic               acs_wr,
  input  logic [DW/8-1:0]    acs_bytes,
  input  logic [AW-1:0]      acs_addr,
  input  logic [DW-1:0]      acs_wdata,
  output logic [DW-1:0]      acs_rdata,
  output logic               acs_ready,
  output logic               acs_error,
  output logic [NSLV-1:0]    slv_cen,
  output logic               slv_wr,
  output logic [DW/8-1:0]    slv_strb,
  output logic [AW-1:0]      slv_addr,
  output logic [DW-1:0]      slv_wdata,
  input  logic [NSLV*DW-1:0] slv_rdata,
  input  logic [NSLV-1:0]    slv_ready,
  input  logic [NSLV-1:0]    slv_error,
  output logic [ECW-1:0]     err_count
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   sel_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [DW-1:0]   acs_rdata_q;
  logic            acs_ready_q;
  logic            acs_error_q;
  logic [NSLV-1:0] slv_cen_q;
  logic            slv_wr_q;
  logic [SW-1:0]   slv_strb_q;
  logic [AW-1:0]   slv_addr_q;
  logic [DW-1:0]   slv_wdata_q;
  logic [ECW-1:0]  err_count_q;

  logic            hit_c;
  logic [IW-1:0]   hit_idx_c;
  logic [AW-1:0]   hit_off_c;
  logic            sel_ready_c;
  logic            sel_error_c;
  logic [DW-1:0]   sel_rdata_c;
  logic            timeout_c;

  // Address decode; the first matching window in ascending index order wins.
  always_comb begin
    hit_c     = 1'b0;
    hit_idx_c = '0;
    hit_off_c = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit_c && ((acs_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit_c     = 1'b1;
        hit_idx_c = IW'(i);
        hit_off_c = acs_addr & ~SLV_MASK[i*AW +: AW];
      end
    end
  end

  assign sel_ready_c = slv_ready[sel_q];
  assign sel_error_c = slv_error[sel_q];
  assign sel_rdata_c = slv_rdata[32'(sel_q)*DW +: DW];
  assign timeout_c   = (TIMEOUT != 0) && (wait_cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      wait_cnt_q  <= '0;
      acs_rdata_q <= '0;
      acs_ready_q <= 1'b0;
      acs_error_q <= 1'b0;
      slv_cen_q   <= '0;
      slv_wr_q    <= 1'b0;
      slv_strb_q  <= '0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      err_count_q <= '0;
    end else begin
      acs_ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acs_en) begin
            if (hit_c) begin
              sel_q       <= hit_idx_c;
              slv_cen_q   <= NSLV'(1) << hit_idx_c;
              slv_wr_q    <= acs_wr;
              slv_strb_q  <= acs_bytes;
              slv_addr_q  <= hit_off_c;
              slv_wdata_q <= acs_wdata;
              wait_cnt_q  <= '0;
              state_q     <= ST_WAIT;
            end else begin
              acs_ready_q <= 1'b1;
              acs_error_q <= 1'b1;
              acs_rdata_q <= '0;
              state_q     <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q + CW'(1);
          // A slave completing on the watchdog's last cycle still counts as a response.
          if (sel_ready_c) begin
            slv_cen_q   <= '0;
            acs_ready_q <= 1'b1;
            acs_error_q <= sel_error_c;
            acs_rdata_q <= slv_wr_q ? '0 : sel_rdata_c;
            state_q     <= ST_RESP;
          end else if (timeout_c) begin
            slv_cen_q   <= '0;
            acs_ready_q <= 1'b1;
            acs_error_q <= 1'b1;
            acs_rdata_q <= '0;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (acs_error_q && !(&err_count_q)) begin
            err_count_q <= err_count_q + ECW'(1);
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acs_rdata = acs_rdata_q;
  assign acs_ready = acs_ready_q;
  assign acs_error = acs_error_q;
  assign slv_cen   = slv_cen_q;
  assign slv_wr    = slv_wr_q;
  assign slv_strb  = slv_strb_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;
  assign err_count = err_count_q;

endmodule
